// File: rtl/line_buffer_ctrl_if.sv
// Pixel-source, line-RAM strobe and window-report bundle for line_buffer_ctrl.
// master = pixel source / datapath side, slave = the controller.
interface line_buffer_ctrl_if #(
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int K     = 3
);
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic          start;
   logic          pix_valid;
   logic          pix_ready;
   logic [K-2:0]  ram_wr_en;
   logic [K-2:0]  ram_rd_en;
   logic          win_valid;
   logic [RW-1:0] win_row;
   logic [CW-1:0] win_col;
   logic          busy;
   logic          done;

   modport master (
      output start, pix_valid,
      input  pix_ready, ram_wr_en, ram_rd_en, win_valid, win_row, win_col, busy, done
   );

   modport slave (
      input  start, pix_valid,
      output pix_ready, ram_wr_en, ram_rd_en, win_valid, win_row, win_col, busy, done
   );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: RAM j strobes trail each accepted pixel by j cycles, window flag by K-1.
// Backpressure: pix_ready only while ACTIVE; stalls become bubbles in the delay line, never merged.
module line_buffer_ctrl #(
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int K     = 3
) (
   input  logic clk,
   input  logic rst,
   line_buffer_ctrl_if.slave lb
);
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int FW = $clog2(K);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [FW-1:0] flush_q, flush_d;
   logic          accept;

   // Stage j carries {accept, row, col} of the pixel accepted j cycles ago.
   logic          st_acc [K-1];
   logic [RW-1:0] st_row [K-1];
   logic [CW-1:0] st_col [K-1];

   logic          win_vld_q;
   logic [RW-1:0] win_row_q;
   logic [CW-1:0] win_col_q;
   logic          win_hit;

   assign accept = lb.pix_valid && (state_q == ACTIVE);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      flush_d = flush_q;
      case (state_q)
         IDLE: begin
            if (lb.start) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (accept) begin
               if (col_q == CW'(IMG_W-1)) begin
                  col_d = '0;
                  if (row_q == RW'(IMG_H-1)) begin
                     row_d   = '0;
                     flush_d = '0;
                     state_d = FLUSH;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         FLUSH: begin
            if (flush_q == FW'(K-2)) state_d = DONE;
            else                     flush_d = flush_q + FW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         flush_q <= flush_d;
      end
   end

   assign st_acc[0] = accept;
   assign st_row[0] = row_q;
   assign st_col[0] = col_q;

   if (K > 2) begin : g_dly
      logic          dly_acc_q [K-2];
      logic [RW-1:0] dly_row_q [K-2];
      logic [CW-1:0] dly_col_q [K-2];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s < K-2; s++) begin
               dly_acc_q[s] <= 1'b0;
               dly_row_q[s] <= '0;
               dly_col_q[s] <= '0;
            end
         end else begin
            dly_acc_q[0] <= st_acc[0];
            dly_row_q[0] <= st_row[0];
            dly_col_q[0] <= st_col[0];
            for (int s = 1; s < K-2; s++) begin
               dly_acc_q[s] <= dly_acc_q[s-1];
               dly_row_q[s] <= dly_row_q[s-1];
               dly_col_q[s] <= dly_col_q[s-1];
            end
         end
      end

      for (genvar j = 1; j <= K-2; j++) begin : g_tap
         assign st_acc[j] = dly_acc_q[j-1];
         assign st_row[j] = dly_row_q[j-1];
         assign st_col[j] = dly_col_q[j-1];
      end
   end

   // RAM j is written from row j onward and read from row j+1 onward.
   for (genvar j = 0; j <= K-2; j++) begin : g_strobe
      if (j == 0) begin : g_first
         assign lb.ram_wr_en[j] = st_acc[j];
      end else begin : g_rest
         assign lb.ram_wr_en[j] = st_acc[j] && (st_row[j] >= RW'(j));
      end
      assign lb.ram_rd_en[j] = st_acc[j] && (st_row[j] >= RW'(j+1));
   end

   assign win_hit = st_acc[K-2] && (st_row[K-2] >= RW'(K-1)) && (st_col[K-2] >= CW'(K-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_vld_q <= 1'b0;
         win_row_q <= '0;
         win_col_q <= '0;
      end else begin
         win_vld_q <= win_hit;
         if (win_hit) begin
            win_row_q <= st_row[K-2];
            win_col_q <= st_col[K-2];
         end
      end
   end

   assign lb.pix_ready = (state_q == ACTIVE);
   assign lb.busy      = (state_q == ACTIVE) || (state_q == FLUSH);
   assign lb.done      = (state_q == DONE);
   assign lb.win_valid = win_vld_q;
   assign lb.win_row   = win_row_q;
   assign lb.win_col   = win_col_q;
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for the chain of K-1 circular line-buffer RAMs that build a KxK convolution window over an IMG_W x IMG_H frame.
- Accepts a raster pixel stream and generates per-RAM wr_en/rd_en strobes, accounting for the 1-cycle RAM read latency.
- Flags when a complete window is available to the MAC array, with window coordinates.
- Sits between the input pixel source and the convolution datapath. Line RAMs are instantiated with DEPTH = IMG_W.

Parameters:
- IMG_W, 10, pixels per row; equals line RAM DEPTH; must be ≥ K.
- IMG_H, 10, rows per frame; must be ≥ K.
- K, 3, kernel size; the controller drives K-1 line RAMs; must be ≥ 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- pix_valid  in  1  source has a pixel this cycle.
- pix_ready  out  1  controller accepts pixels.
- ram_wr_en  out  K-1  write strobe, one per line RAM (bit j = RAM j).
- ram_rd_en  out  K-1  read strobe, one per line RAM.
- win_valid  out  1  window centred on (win_row-1, win_col-1) is complete this cycle.
- win_row  out  clog2(IMG_H)  row index of the newest pixel in the window.
- win_col  out  clog2(IMG_W)  column index of the newest pixel in the window.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately.
- Reset does not touch the RAMs. The system must reset the RAMs together with this block.
- States:
  - IDLE: on start go to ACTIVE; busy=1 from the next cycle.
  - ACTIVE: pix_ready=1. Accept = pix_valid & pix_ready. col/row counters advance on accept (col wraps IMG_W-1→0 and increments row). The last pixel (row=IMG_H-1, col=IMG_W-1) is accepted, then go to FLUSH.
  - FLUSH: pix_ready=0. Hold for K-1 cycles to let delayed strobes drain, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 from that cycle on; go to IDLE.
- start outside IDLE is ignored. pix_valid outside ACTIVE is ignored and produces no strobes.
- Strobe timing for a pixel accepted in cycle t at (r,c), for j = 0..K-2:
  - ram_wr_en[j] high in cycle t+j iff r ≥ j.
  - ram_rd_en[j] high in cycle t+j iff r ≥ j+1.
  - Consequences:
    - wr_en[0]/rd_en[0] are combinational from accept and row.
    - Higher stages come from a (K-2)-deep shift register of {accept, r, c}.
    - RAM j output is valid at t+j+1 and is written into RAM j+1 in that same cycle.
- win_valid high in cycle t+K-1 iff r ≥ K-1 and c ≥ K-1; win_row=r and win_col=c in that cycle. Otherwise win_row/win_col hold their last value.
- Stalls (pix_valid low) insert bubbles into all delayed stages. Strobes are never merged or dropped. Back-to-back accepts give back-to-back strobes.
- Per frame, RAM j sees exactly IMG_W*(IMG_H-j) writes and IMG_W*(IMG_H-j-1) reads. Both are multiples of IMG_W, so RAM pointers return to 0 and consecutive frames need no RAM reset.
- Counters saturate to 0 at frame end; a new start restarts at (0,0).

Test Plan:
- IMG_W=4, IMG_H=4, K=3, start then pix_valid held high:
  - pix_ready high for exactly 16 cycles.
  - wr_en[0]=16, rd_en[0]=12, wr_en[1]=12, rd_en[1]=8 pulses.
  - win_valid=4 pulses at (2,2),(2,3),(3,2),(3,3).
  - done pulses 3 cycles after the last accept (2 FLUSH cycles + DONE).
- Same frame with pix_valid toggling 1,0,1,0:
  - Identical pulse counts and coordinates.
  - Each rd_en[1] pulse lags its pixel's accept by exactly 1 cycle.
- Row-1 boundary: the first accept at row 1 (pixel 4) asserts wr_en[0] and rd_en[0] together; wr_en[1] is high the next cycle, rd_en[1] is not.
- Two consecutive frames with the RAM model attached: window data for frame 2 matches the golden image; no pointer drift.
- Assert rst in the middle of row 2: all outputs 0 immediately, state IDLE. A following start produces a normal frame (with RAMs also reset).
- start pulsed during ACTIVE and during FLUSH: ignored, no counter change. pix_valid during IDLE: no strobes.
